adc_buf_reader: RTL and testbench

- Read side of the ADC capture buffer.
- On a store request from the capture FSM, reads N 16-bit samples from port B of the capture block RAM and packs them two per beat onto a 32-bit AXI4-Stream master toward the PS DMA/DDR path.
- Returns a one-cycle store-done pulse when the last beat has been accepted.
- Single clock domain, clocked with the capture FSM.

---
 rtl/adc_buf_reader.sv | 213 +++++++++++++++++++++
 tb/tb_adc_buf_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_buf_reader.sv
// adc_buf_reader: read side of the ADC capture buffer. A store request reads
// N samples from capture RAM port B and streams them two per beat as 32-bit
// AXI4-Stream. A one-cycle o_store_done pulse marks the end of the transfer.
// Build option ADC_BUF_RD_TWOS_EN: samples are converted from offset binary
// to sign-extended two's complement instead of being zero-extended.
module adc_buf_reader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int RD_LATENCY     = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_store_start,
  input  logic [ADDR_WIDTH-1:0]     i_start_addr,
  input  logic [ADDR_WIDTH:0]       i_num_samples,
  output logic                      o_busy,
  output logic                      o_store_done,
  output logic                      o_enb,
  output logic [ADDR_WIDTH-1:0]     o_addrb,
  input  logic [RAM_DATA_WIDTH-1:0] i_doutb,
  output logic [31:0]               m_axis_tdata,
  output logic [3:0]                m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [NW-1:0]         NUM_ONE  = NW'(1);
  localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  // Convert a raw RAM word into the 16-bit stream sample format.
  function automatic logic [15:0] fmt_sample(input logic [RAM_DATA_WIDTH-1:0] raw);
    logic [11:0] code;
    code = raw[11:0];
`ifdef ADC_BUF_RD_TWOS_EN
    code[11] = ~code[11];
    return {{4{code[11]}}, code};
`else
    return {4'b0000, code};
`endif
  endfunction

  state_t                  state_q;
  logic                    start_q, start_prev_q;
  logic                    busy_q, done_q, enb_q;
  logic [ADDR_WIDTH-1:0]   addrb_q, addr_next_q;
  logic [NW-1:0]           left_q, num_q, popped_q;
  logic [RD_LATENCY-1:0]   vld_q;
  logic [15:0]             fifo_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           fifo_cnt_q;
  logic [15:0]             low_q;
  logic                    have_low_q;
  logic [31:0]             tdata_q;
  logic [3:0]              tkeep_q;
  logic                    tvalid_q, tlast_q;

  logic                    start_edge_d, issue_d, capture_d, pop_low_d, out_free_d;
  logic                    emit_pair_d, emit_single_d, pop_d, last_hs_d;
  logic [OW-1:0]           occ_d;

  // Read scheduling: FIFO entries plus reads still travelling through the RAM pipe.
  always_comb begin
    occ_d = OW'(fifo_cnt_q) + OW'(enb_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      occ_d = occ_d + OW'(vld_q[i]);
    end
    start_edge_d  = start_q & ~start_prev_q;
    issue_d       = (state_q == READ) && (left_q != '0) && (occ_d < OW'(FIFO_DEPTH));
    capture_d     = vld_q[RD_LATENCY-1];
    out_free_d    = ~tvalid_q | m_axis_tready;
    pop_low_d     = ~have_low_q && (fifo_cnt_q != '0);
    emit_pair_d   = have_low_q && (fifo_cnt_q != '0) && out_free_d;
    emit_single_d = have_low_q && (popped_q == num_q) && out_free_d;
    pop_d         = pop_low_d | emit_pair_d;
    last_hs_d     = tvalid_q & m_axis_tready & tlast_q;
  end

  // Control FSM: start edge detection, RAM read issue and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      enb_q        <= 1'b0;
      addrb_q      <= '0;
      addr_next_q  <= '0;
      left_q       <= '0;
      num_q        <= '0;
    end else begin
      start_q      <= i_store_start;
      start_prev_q <= start_q;
      enb_q        <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge_d) begin
            num_q <= i_num_samples;
            if (i_num_samples == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= READ;
              busy_q      <= 1'b1;
              enb_q       <= 1'b1;
              addrb_q     <= i_start_addr;
              addr_next_q <= i_start_addr + ADDR_ONE;
              left_q      <= i_num_samples - NUM_ONE;
            end
          end
        end
        READ: begin
          if (left_q == '0) begin
            state_q <= DRAIN;
          end else if (issue_d) begin
            enb_q       <= 1'b1;
            addrb_q     <= addr_next_q;
            addr_next_q <= addr_next_q + ADDR_ONE;
            left_q      <= left_q - NUM_ONE;
          end
        end
        DRAIN: begin
          if (last_hs_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: RAM return pipe, sample FIFO, pairing register and stream output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      low_q      <= '0;
      have_low_q <= 1'b0;
      popped_q   <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      vld_q[0] <= enb_q;
      for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      if (capture_d) begin
        fifo_q[wr_ptr_q] <= fmt_sample(i_doutb);
        wr_ptr_q         <= wr_ptr_q + PTR_ONE;
      end
      if (pop_d) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({capture_d, pop_d})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (state_q == IDLE) popped_q <= '0;
      else if (pop_d)      popped_q <= popped_q + NUM_ONE;
      if (pop_low_d) begin
        low_q      <= fifo_q[rd_ptr_q];
        have_low_q <= 1'b1;
      end else if (emit_pair_d || emit_single_d) begin
        have_low_q <= 1'b0;
      end
      if (emit_pair_d) begin
        tdata_q  <= {fifo_q[rd_ptr_q], low_q};
        tkeep_q  <= 4'b1111;
        tlast_q  <= ((popped_q + NUM_ONE) == num_q);
        tvalid_q <= 1'b1;
      end else if (emit_single_d) begin
        tdata_q  <= {16'h0000, low_q};
        tkeep_q  <= 4'b0011;
        tlast_q  <= 1'b1;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign o_busy        = busy_q;
  assign o_store_done  = done_q;
  assign o_enb         = enb_q;
  assign o_addrb       = addrb_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_adc_buf_reader.sv
// Scoreboard bench for adc_buf_reader: stimulus pushes expected beats and
// read addresses; a negedge monitor compares whatever the DUT presents.
module tb_adc_buf_reader;

  logic        clk;
  logic        rst_n;
  logic        i_store_start;
  logic [11:0] i_start_addr;
  logic [12:0] i_num_samples;
  logic        o_busy, o_store_done, o_enb;
  logic [11:0] o_addrb;
  logic [15:0] i_doutb;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

  adc_buf_reader dut (
    .clk(clk), .rst_n(rst_n), .i_store_start(i_store_start),
    .i_start_addr(i_start_addr), .i_num_samples(i_num_samples),
    .o_busy(o_busy), .o_store_done(o_store_done), .o_enb(o_enb),
    .o_addrb(o_addrb), .i_doutb(i_doutb), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_beat_q[$];
  logic [11:0] exp_addr_q[$];
  logic [15:0] ram [0:4095];
  int checks = 0, errors = 0;
  int enb_cnt = 0, beat_cnt = 0, done_cnt = 0;
  int tready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM port B model, one cycle read latency
  always @(posedge clk) begin
    if (o_enb) i_doutb <= ram[o_addrb];
  end

  // Sink ready: 0 = always ready, 1 = random 50%, 2 = stalled
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (tready_mode == 0)      m_axis_tready = 1'b1;
      else if (tready_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
      else                       m_axis_tready = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_beat_q.push_back(b);
  endtask

  task automatic push_addrs(input int start, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(12'(start + i));
  endtask

  task automatic start_xfer(input logic [11:0] addr, input logic [12:0] n);
    @(posedge clk); #2;
    i_store_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    i_start_addr  = addr;
    i_num_samples = n;
    i_store_start = 1'b1;
  endtask

  task automatic wait_done(input string name, input int base, input int budget);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == base) begin
      checks++; errors++;
      $display("FAIL %s: timeout, got no done after %0d cycles expected a done pulse", name, budget);
    end
  endtask

  task automatic chk_idle_end(input string name, input int done_base);
    repeat (4) @(posedge clk);
    chk({name, "_done_count"}, 64'(done_cnt - done_base), 64'd1);
    chk({name, "_beats_left"}, 64'(exp_beat_q.size()), 64'd0);
    chk({name, "_reads_left"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  // Monitor: scoreboards reads, beats, stability under backpressure and done timing
  beat_t saved;
  logic  stall_p = 1'b0, last_hs_p = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0; last_hs_p = 1'b0; prev_done = 1'b0;
    end else begin
      if (o_enb) begin
        enb_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got read at 0x%0h expected no read", o_addrb);
        end else chk("read_addr", 64'(o_addrb), 64'(exp_addr_q.pop_front()));
      end
      if (stall_p) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_payload", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(saved));
      end
      if (last_hs_p) chk("done_after_tlast", 64'(o_store_done), 64'd1);
      if (o_store_done) begin
        done_cnt++;
        chk("done_one_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = o_store_done;
      last_hs_p = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got 0x%08h expected no beat", m_axis_tdata);
        end else begin
          beat_t e;
          e = exp_beat_q.pop_front();
          chk("beat_data", 64'(m_axis_tdata), 64'(e.d));
          chk("beat_keep", 64'(m_axis_tkeep), 64'(e.k));
          chk("beat_last", 64'(m_axis_tlast), 64'(e.l));
        end
        if (m_axis_tlast) last_hs_p = 1'b1;
      end
      stall_p = m_axis_tvalid && !m_axis_tready;
      saved   = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end

  initial begin
    int base, ebase, bbase, lat;
    rst_n = 1'b0; i_store_start = 1'b0; i_start_addr = 12'd0; i_num_samples = 13'd0;
    for (int a = 0; a < 4096; a++) ram[a] = 16'(a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stream", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'd0);
    chk("reset_ctrl", 64'({o_busy, o_store_done, o_enb, o_addrb}), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Case 1: addr 0, N = 8, sink always ready
    tready_mode = 0;
    push_beat(32'h00010000, 4'hF, 1'b0); push_beat(32'h00030002, 4'hF, 1'b0);
    push_beat(32'h00050004, 4'hF, 1'b0); push_beat(32'h00070006, 4'hF, 1'b1);
    push_addrs(0, 8);
    base = done_cnt;
    start_xfer(12'd0, 13'd8);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin lat = k; break; end
    end
    // one sampling edge plus observation at the following negedge on top of RD_LATENCY+4
    chk("first_valid_latency_ok", 64'(lat >= 1 && lat <= 7), 64'd1);
    chk("busy_during_xfer", 64'(o_busy), 64'd1);
    wait_done("case1", base, 200);
    chk_idle_end("case1", base);

    // Case 2: wrap from 4094, N = 5, odd tail
    push_beat(32'h0FFF0FFE, 4'hF, 1'b0); push_beat(32'h00010000, 4'hF, 1'b0);
    push_beat(32'h00000002, 4'h3, 1'b1);
    push_addrs(4094, 5);
    base = done_cnt;
    start_xfer(12'd4094, 13'd5);
    wait_done("case2", base, 200);
    chk_idle_end("case2", base);

    // Case 3: N = 8, stalled sink then random ready
    push_beat(32'h00010000, 4'hF, 1'b0); push_beat(32'h00030002, 4'hF, 1'b0);
    push_beat(32'h00050004, 4'hF, 1'b0); push_beat(32'h00070006, 4'hF, 1'b1);
    push_addrs(0, 8);
    base = done_cnt; ebase = enb_cnt;
    tready_mode = 2;
    start_xfer(12'd0, 13'd8);
    repeat (30) @(posedge clk);
    // FIFO_DEPTH samples, one held beat and one half-beat at most
    chk("stall_reads_bounded", 64'((enb_cnt - ebase) <= 7), 64'd1);
    tready_mode = 1;
    wait_done("case3", base, 400);
    tready_mode = 0;
    chk_idle_end("case3", base);

    // Case 4: N = 0, held start level must not retrigger
    base = done_cnt; ebase = enb_cnt; bbase = beat_cnt;
    @(posedge clk); #2; i_store_start = 1'b0;
    repeat (3) @(posedge clk);
    #2; i_start_addr = 12'd10; i_num_samples = 13'd0; i_store_start = 1'b1;
    @(negedge clk); chk("n0_done_c0", 64'(o_store_done), 64'd0);
    @(negedge clk); chk("n0_done_c1", 64'(o_store_done), 64'd0);
    @(negedge clk); chk("n0_done_c2", 64'(o_store_done), 64'd1);
    @(negedge clk); chk("n0_done_c3", 64'(o_store_done), 64'd0);
    repeat (20) @(posedge clk);
    chk("n0_single_pulse", 64'(done_cnt - base), 64'd1);
    chk("n0_no_reads", 64'(enb_cnt - ebase), 64'd0);
    chk("n0_no_beats", 64'(beat_cnt - bbase), 64'd0);

    // Case 5: reset after beat 2 of N = 16, then a full new transfer
    for (int k = 0; k < 8; k++) push_beat({16'(2*k+1), 16'(2*k)}, 4'hF, k == 7);
    push_addrs(0, 16);
    base = done_cnt; bbase = beat_cnt;
    start_xfer(12'd0, 13'd16);
    for (int k = 0; k < 100 && (beat_cnt - bbase) < 2; k++) @(posedge clk);
    chk("pre_reset_beats", 64'(beat_cnt - bbase), 64'd2);
    #2; rst_n = 1'b0; i_store_start = 1'b0;
    exp_beat_q.delete(); exp_addr_q.delete();
    @(negedge clk);
    chk("abort_stream", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'd0);
    chk("abort_ctrl", 64'({o_busy, o_store_done, o_enb, o_addrb}), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("abort_no_done", 64'(done_cnt - base), 64'd0);
    for (int k = 0; k < 8; k++) push_beat({16'(2*k+1), 16'(2*k)}, 4'hF, k == 7);
    push_addrs(0, 16);
    bbase = beat_cnt;
    start_xfer(12'd0, 13'd16);
    wait_done("restart", base, 300);
    chk("restart_beats", 64'(beat_cnt - bbase), 64'd8);
    chk_idle_end("restart", base);

    // Case 6: sample format, upper RAM bits must not leak
    ram[200] = 16'h5800; ram[201] = 16'hA000; ram[202] = 16'hFFFF; ram[203] = 16'h07FF;
`ifdef ADC_BUF_RD_TWOS_EN
    push_beat(32'hF8000000, 4'hF, 1'b0); push_beat(32'hFFFF07FF, 4'hF, 1'b1);
`else
    push_beat(32'h00000800, 4'hF, 1'b0); push_beat(32'h07FF0FFF, 4'hF, 1'b1);
`endif
    push_addrs(200, 4);
    base = done_cnt;
    start_xfer(12'd200, 13'd4);
    wait_done("format", base, 200);
    chk_idle_end("format", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
